// File: rtl/writeback_stage_pkg.sv
// Shared types and constants for the writeback stage: payload layout, CSR map, FSM states.
package writeback_stage_pkg;

   typedef enum logic [1:0] {CSR_NONE, CSR_RW, CSR_RS, CSR_RC} csr_op_e;

   typedef enum logic {WB_RUN, WB_TRAP} wb_state_e;

   localparam logic [11:0] CSR_MSTATUS   = 12'h300;
   localparam logic [11:0] CSR_MTVEC     = 12'h305;
   localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
   localparam logic [11:0] CSR_MEPC      = 12'h341;
   localparam logic [11:0] CSR_MCAUSE    = 12'h342;
   localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
   localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
   localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
   localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

   localparam int unsigned MSTATUS_MIE_BIT  = 3;
   localparam int unsigned MSTATUS_MPIE_BIT = 7;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic        illegal;
      logic        writeback_enable;
      logic [4:0]  rd;
      logic [31:0] data;
      csr_op_e     csr_op;
      logic        csr_write_intent;
      logic [31:0] old_csr_value;
      logic [11:0] csr_addr;
   } mem_wb_payload_t;

   // Bits software can actually store at each address; unmapped addresses store nothing.
   function automatic logic [31:0] csr_wmask(logic [11:0] addr);
      logic [31:0] m;
      m = '0;
      case (addr)
         CSR_MSTATUS: begin
            m[MSTATUS_MIE_BIT]  = 1'b1;
            m[MSTATUS_MPIE_BIT] = 1'b1;
         end
         CSR_MTVEC, CSR_MEPC: m = 32'hFFFF_FFFC;
         CSR_MSCRATCH, CSR_MCAUSE, CSR_MCYCLE, CSR_MCYCLEH,
         CSR_MINSTRET, CSR_MINSTRETH: m = 32'hFFFF_FFFF;
         default: m = '0;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/writeback_stage_if.sv
// Memory-to-writeback link: registered payload and stall forward, flush back upstream.
interface writeback_stage_if;
   import writeback_stage_pkg::*;

   mem_wb_payload_t payload;
   logic            stall;
   logic            flush;

   modport master (output payload, output stall, input flush);
   modport slave  (input payload, input stall, output flush);

endinterface

// File: rtl/writeback_stage_csr_file.sv
// Machine CSR storage, 64-bit cycle/instret counters, read mux with same-cycle write bypass.
module writeback_stage_csr_file
   import writeback_stage_pkg::*;
#(
   parameter logic [31:0] MTVEC_RESET = 32'h0000_0100
) (
   input  logic        clock_i,
   input  logic        reset_ni,
   input  logic        write_enable_i,
   input  logic [11:0] write_address_i,
   input  logic [31:0] write_data_i,
   input  logic        instret_inc_i,
   input  logic        trap_i,
   input  logic [31:0] trap_epc_i,
   input  logic [31:0] trap_cause_i,
   input  logic [11:0] read_address_i,
   output logic [31:0] read_data_o,
   output logic        mie_o,
   output logic [31:0] mtvec_o
);

   logic        mie_q, mie_d, mpie_q, mpie_d;
   logic [31:0] mtvec_q, mtvec_d, mscratch_q, mscratch_d;
   logic [31:0] mepc_q, mepc_d, mcause_q, mcause_d;
   logic [63:0] mcycle_q, mcycle_d, minstret_q, minstret_d;
   logic [31:0] wval, stored;

   assign wval = write_data_i & csr_wmask(write_address_i);

   always_comb begin
      mie_d      = mie_q;
      mpie_d     = mpie_q;
      mtvec_d    = mtvec_q;
      mscratch_d = mscratch_q;
      mepc_d     = mepc_q;
      mcause_d   = mcause_q;
      // Full 64-bit add keeps the lo->hi carry atomic; a written half then overrides it.
      mcycle_d   = mcycle_q + 64'd1;
      minstret_d = minstret_q + {63'd0, instret_inc_i};
      if (write_enable_i) begin
         case (write_address_i)
            CSR_MSTATUS: begin
               mie_d  = wval[MSTATUS_MIE_BIT];
               mpie_d = wval[MSTATUS_MPIE_BIT];
            end
            CSR_MTVEC:     mtvec_d            = wval;
            CSR_MSCRATCH:  mscratch_d         = wval;
            CSR_MEPC:      mepc_d             = wval;
            CSR_MCAUSE:    mcause_d           = wval;
            CSR_MCYCLE:    mcycle_d[31:0]     = wval;
            CSR_MCYCLEH:   mcycle_d[63:32]    = wval;
            CSR_MINSTRET:  minstret_d[31:0]   = wval;
            CSR_MINSTRETH: minstret_d[63:32]  = wval;
            default: ;
         endcase
      end
      // Trap entry sees the instruction's own mstatus write, then clears MIE.
      if (trap_i) begin
         mpie_d   = mie_d;
         mie_d    = 1'b0;
         mepc_d   = trap_epc_i & 32'hFFFF_FFFC;
         mcause_d = trap_cause_i;
      end
   end

   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         mie_q      <= 1'b0;
         mpie_q     <= 1'b0;
         mtvec_q    <= MTVEC_RESET & 32'hFFFF_FFFC;
         mscratch_q <= '0;
         mepc_q     <= '0;
         mcause_q   <= '0;
         mcycle_q   <= '0;
         minstret_q <= '0;
      end else begin
         mie_q      <= mie_d;
         mpie_q     <= mpie_d;
         mtvec_q    <= mtvec_d;
         mscratch_q <= mscratch_d;
         mepc_q     <= mepc_d;
         mcause_q   <= mcause_d;
         mcycle_q   <= mcycle_d;
         minstret_q <= minstret_d;
      end
   end

   always_comb begin
      stored = '0;
      case (read_address_i)
         CSR_MSTATUS: begin
            stored[MSTATUS_MIE_BIT]  = mie_q;
            stored[MSTATUS_MPIE_BIT] = mpie_q;
         end
         CSR_MTVEC:     stored = mtvec_q;
         CSR_MSCRATCH:  stored = mscratch_q;
         CSR_MEPC:      stored = mepc_q;
         CSR_MCAUSE:    stored = mcause_q;
         CSR_MCYCLE:    stored = mcycle_q[31:0];
         CSR_MCYCLEH:   stored = mcycle_q[63:32];
         CSR_MINSTRET:  stored = minstret_q[31:0];
         CSR_MINSTRETH: stored = minstret_q[63:32];
         default:       stored = '0;
      endcase
      read_data_o = (write_enable_i && (write_address_i == read_address_i)) ? wval : stored;
   end

   assign mie_o   = mie_q;
   assign mtvec_o = mtvec_q;

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: retires payloads into the register file, updates CSRs, takes traps.
module writeback_stage
   import writeback_stage_pkg::*;
#(
   parameter logic [31:0] MTVEC_RESET   = 32'h0000_0100,
   parameter logic [31:0] ILLEGAL_CAUSE = 32'd2,
   parameter logic [31:0] IRQ_CAUSE     = 32'h8000_000B
) (
   input  logic              clock_i,
   input  logic              reset_ni,
   writeback_stage_if.slave  mem_wb_io,
   input  logic              interrupt_i,
   output logic              reg_write_enable_o,
   output logic [4:0]        reg_write_address_o,
   output logic [31:0]       reg_write_data_o,
   input  logic [11:0]       csr_read_address_i,
   output logic [31:0]       csr_read_data_o,
   output logic              redirect_valid_o,
   output logic [31:0]       redirect_pc_o
);

   wb_state_e       state_q, state_d;
   logic            committed_q, committed_d;
   mem_wb_payload_t pl;
   logic            live, retire, irq_take, trap, csr_active, csr_we, mie;
   logic [31:0]     csr_wdata, mtvec, trap_epc, trap_cause;

   assign pl = mem_wb_io.payload;

   always_comb begin
      live       = pl.valid & ~committed_q & (state_q == WB_RUN);
      retire     = live & ~pl.illegal;
      irq_take   = retire & interrupt_i & mie;
      trap       = (live & pl.illegal) | irq_take;
      csr_active = (pl.csr_op != CSR_NONE);
      csr_we     = retire & pl.csr_write_intent & csr_active;
      trap_epc   = pl.illegal ? pl.pc : pl.pc + 32'd4;
      trap_cause = pl.illegal ? ILLEGAL_CAUSE : IRQ_CAUSE;
      case (pl.csr_op)
         CSR_RS:  csr_wdata = pl.old_csr_value | pl.data;
         CSR_RC:  csr_wdata = pl.old_csr_value & ~pl.data;
         default: csr_wdata = pl.data;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      committed_d = committed_q;
      case (state_q)
         WB_RUN:  if (trap) state_d = WB_TRAP;
         WB_TRAP: state_d = WB_RUN;
         default: state_d = WB_RUN;
      endcase
      // A payload held under stall must commit only once.
      if (!mem_wb_io.stall) begin
         committed_d = 1'b0;
      end else if (live) begin
         committed_d = 1'b1;
      end
   end

   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q     <= WB_RUN;
         committed_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         committed_q <= committed_d;
      end
   end

   always_comb begin
      reg_write_enable_o  = retire & pl.writeback_enable & (pl.rd != 5'd0);
      reg_write_address_o = reg_write_enable_o ? pl.rd : 5'd0;
      reg_write_data_o    = '0;
      if (reg_write_enable_o) begin
         reg_write_data_o = csr_active ? pl.old_csr_value : pl.data;
      end
      mem_wb_io.flush  = (state_q == WB_TRAP);
      redirect_valid_o = (state_q == WB_TRAP);
      redirect_pc_o    = (state_q == WB_TRAP) ? mtvec : 32'd0;
   end

   writeback_stage_csr_file #(
      .MTVEC_RESET (MTVEC_RESET)
   ) u_csr_file (
      .clock_i         (clock_i),
      .reset_ni        (reset_ni),
      .write_enable_i  (csr_we),
      .write_address_i (pl.csr_addr),
      .write_data_i    (csr_wdata),
      .instret_inc_i   (retire),
      .trap_i          (trap),
      .trap_epc_i      (trap_epc),
      .trap_cause_i    (trap_cause),
      .read_address_i  (csr_read_address_i),
      .read_data_o     (csr_read_data_o),
      .mie_o           (mie),
      .mtvec_o         (mtvec)
   );

endmodule
